// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction-fetch front end:
//     - OP_WIDTH          : opcode field width of a MIPS32 instruction
//     - TRUE / FALSE      : single-bit boolean constants
//     - RESET_PC_DEFAULT  : default PC after reset
//     - INSTR_OP_HI/LO    : opcode field bounds inside the instruction word
//     - fetch_state_t     : FSM state encodings (FETCH_IDLE / FETCH_REQ)
//     - is_word_aligned() : alignment check for redirect targets
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int OP_WIDTH    = 6;
  localparam int INSTR_OP_HI = 31;
  localparam int INSTR_OP_LO = 26;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//   Program-counter register of the fetch front end.
//   Owns the PC, the link value (address of latched instruction + 4), the
//   pending-redirect register used while a fetch is outstanding, and the
//   alignment check on redirect targets.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   pc_load          redirect request
//   pc_load_val      redirect target
//   idle             fetch FSM is in IDLE
//   complete         outstanding fetch completes this cycle (REQ & rvalid)
//   fetch_addr       address of the outstanding fetch (imem_addr)
//   next_fetch_addr  address a fetch started this cycle should use
//   pc               current PC
//   pc_plus4         address of the latched instruction + 4
//   addr_err         one-cycle pulse after a misaligned redirect
// -----------------------------------------------------------------------------
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              idle,
  input  logic              complete,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] next_fetch_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              addr_err
);

  logic              load_aligned;
  logic              load_ok;
  logic [ADDR_W-1:0] addr_plus4;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_vld;

  // A misaligned target is dropped entirely; only addr_err reports it.
  assign load_aligned = is_word_aligned(pc_load_val[1:0]);
  assign load_ok      = pc_load & load_aligned;

  // Modulo 2^ADDR_W: 0xFFFF_FFFC + 4 wraps to 0.
  assign addr_plus4 = fetch_addr + ADDR_W'(4);

  // A redirect arriving together with fetch_start wins over the current PC.
  assign next_fetch_addr = load_ok ? pc_load_val : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      pc_plus4 <= RESET_PC + ADDR_W'(4);
      pend_vld <= FALSE;
      addr_err <= FALSE;
    end else begin
      addr_err <= pc_load & ~load_aligned;
      if (idle) begin
        if (load_ok) begin
          pc <= pc_load_val;
        end
        pend_vld <= FALSE;
      end else if (complete) begin
        // A redirect on the completion cycle is newer than any pending one.
        if (load_ok) begin
          pc <= pc_load_val;
        end else if (pend_vld) begin
          pc <= pend_addr;
        end else begin
          pc <= addr_plus4;
        end
        pc_plus4 <= addr_plus4;
        pend_vld <= FALSE;
      end else if (load_ok) begin
        pend_vld <= TRUE;
      end
    end
  end

  // Pending target is pure data; pend_vld alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!idle && !complete && load_ok) begin
      pend_addr <= pc_load_val;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end of the multicycle MIPS32 core. On a
//   fetch_start strobe it issues one request to instruction memory, holds
//   imem_req/imem_addr stable until imem_rvalid, then latches the instruction,
//   presents op_code and pulses fetch_done. PC redirects may arrive at any
//   time; during a fetch they are deferred until completion.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   fetch_start   single-cycle fetch strobe from the sequencer
//   pc_load       redirect request, pc_load_val = target
//   imem_req      memory request, held until imem_rvalid
//   imem_addr     word-aligned fetch address
//   imem_rvalid   read data valid (completes the request)
//   imem_rdata    instruction word
//   pc            current PC
//   pc_plus4      address of latched instruction + 4 (JAL link)
//   instr         latched instruction, op_code = its top OP_W bits
//   fetch_done    one-cycle pulse when instr updates
//   busy          fetch outstanding
//   addr_err      one-cycle pulse on a misaligned redirect target
//   overrun       sticky: fetch_start seen while busy
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                OP_W     = OP_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] instr,
  output logic [OP_W-1:0]   op_code,
  output logic              fetch_done,
  output logic              busy,
  output logic              addr_err,
  output logic              overrun
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic              idle;
  logic              start;
  logic              complete;
  logic [ADDR_W-1:0] next_fetch_addr;

  logic              req_d;
  logic              busy_d;
  logic              done_d;
  logic              overrun_d;

  assign idle     = (state_q == FETCH_IDLE);
  assign start    = idle & fetch_start;
  // rvalid outside REQ (e.g. a late response after reset) is ignored.
  assign complete = (state_q == FETCH_REQ) & imem_rvalid;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .pc_load         (pc_load),
    .pc_load_val     (pc_load_val),
    .idle            (idle),
    .complete        (complete),
    .fetch_addr      (imem_addr),
    .next_fetch_addr (next_fetch_addr),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .addr_err        (addr_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: if (fetch_start) state_d = FETCH_REQ;
      FETCH_REQ:  if (imem_rvalid) state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_d     = (state_d == FETCH_REQ);
    busy_d    = (state_d == FETCH_REQ);
    done_d    = complete;
    overrun_d = overrun | (~idle & fetch_start);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req   <= FALSE;
      busy       <= FALSE;
      fetch_done <= FALSE;
      overrun    <= FALSE;
      imem_addr  <= RESET_PC;
      instr      <= '0;
    end else begin
      imem_req   <= req_d;
      busy       <= busy_d;
      fetch_done <= done_d;
      overrun    <= overrun_d;
      // Address is captured once at start and held for the whole request.
      if (start) begin
        imem_addr <= next_fetch_addr;
      end
      if (complete) begin
        instr <= imem_rdata;
      end
    end
  end

  assign op_code = instr[DATA_W-1 -: OP_W];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [5:0]  op_code;
  logic        fetch_done;
  logic        busy;
  logic        addr_err;
  logic        overrun;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .op_code     (op_code),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .addr_err    (addr_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] pp4;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   pushed   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every fetch_done pops one expected completion.
  always @(negedge clk) begin
    if (fetch_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch_done: got 1 expected 0 (instr=%h)", instr);
      end else begin
        e = sb.pop_front();
        chk("done_instr", instr, e.instr);
        chk("done_op_code", 32'(op_code), 32'(e.op));
        chk("done_pc", pc, e.pc);
        chk("done_pc_plus4", pc_plus4, e.pp4);
      end
    end
  end

  // One fetch: starts at a negedge in IDLE, ends at the negedge after completion.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input logic [5:0] exp_op, input int ws,
                       input logic [31:0] exp_pc, input logic [31:0] exp_pp4,
                       input logic ld_now, input logic [31:0] ld_now_val,
                       input int redir_cyc, input logic [31:0] redir_val,
                       input logic dbl_start);
    exp_t e;
    e.instr = rdata; e.op = exp_op; e.pc = exp_pc; e.pp4 = exp_pp4;
    sb.push_back(e);
    pushed++;
    fetch_start = 1'b1;
    pc_load     = ld_now;
    pc_load_val = ld_now_val;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    for (int i = 0; i <= ws; i++) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, exp_addr);
      chk("busy_held", 32'(busy), 32'd1);
      chk("no_early_done", 32'(fetch_done), 32'd0);
      fetch_start = dbl_start && (i == 0);
      pc_load     = (i == redir_cyc);
      pc_load_val = redir_val;
      imem_rvalid = (i == ws);
      imem_rdata  = (i == ws) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    imem_rvalid = 1'b0;
    chk("req_dropped", 32'(imem_req), 32'd0);
    chk("busy_dropped", 32'(busy), 32'd0);
    @(negedge clk);
    chk("single_done_pulse", 32'(fetch_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_load_val = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fetch_done", 32'(fetch_done), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Basic fetch, zero wait states
    fetch(32'h0, 32'h2408_0005, 6'h09, 0, 32'h4, 32'h4, 1'b0, 32'h0, -1, 32'h0, 1'b0);
    chk("basic_pc", pc, 32'h4);

    // Three wait states
    fetch(32'h4, 32'h8C09_0000, 6'h23, 3, 32'h8, 32'h8, 1'b0, 32'h0, -1, 32'h0, 1'b0);

    // Redirect while waiting, then next fetch goes to the target
    fetch(32'h8, 32'h1000_0003, 6'h04, 2, 32'h100, 32'hC, 1'b0, 32'h0, 1, 32'h100, 1'b0);
    fetch(32'h100, 32'h0800_0040, 6'h02, 0, 32'h104, 32'h104, 1'b0, 32'h0, -1, 32'h0, 1'b0);

    // Redirect on the completion cycle counts as pending
    fetch(32'h104, 32'h0C00_0010, 6'h03, 1, 32'h200, 32'h108, 1'b0, 32'h0, 1, 32'h200, 1'b0);

    // fetch_start + pc_load in the same IDLE cycle
    fetch(32'h40, 32'h0000_0020, 6'h00, 0, 32'h44, 32'h44, 1'b1, 32'h40, -1, 32'h0, 1'b0);

    // Misaligned load in IDLE is dropped
    pc_load = 1'b1; pc_load_val = 32'h42;
    @(negedge clk);
    pc_load = 1'b0;
    chk("misalign_addr_err", 32'(addr_err), 32'd1);
    chk("misalign_pc", pc, 32'h44);
    @(negedge clk);
    chk("misalign_err_pulse", 32'(addr_err), 32'd0);
    chk("misalign_pc_hold", pc, 32'h44);

    // Misaligned load together with fetch_start: fetch uses old pc
    fetch(32'h44, 32'h2129_0001, 6'h08, 0, 32'h48, 32'h48, 1'b1, 32'h46, -1, 32'h0, 1'b0);

    // Aligned load in IDLE
    pc_load = 1'b1; pc_load_val = 32'h300;
    @(negedge clk);
    pc_load = 1'b0;
    chk("idle_load_pc", pc, 32'h300);
    chk("idle_load_no_err", 32'(addr_err), 32'd0);
    chk("hold_instr", instr, 32'h2129_0001);
    chk("hold_pc_plus4", pc_plus4, 32'h48);

    // fetch_start while busy: overrun, one completion only
    fetch(32'h300, 32'hAC0A_0004, 6'h2B, 2, 32'h304, 32'h304, 1'b0, 32'h0, -1, 32'h0, 1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    repeat (2) @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("overrun_no_extra_req", 32'(imem_req), 32'd0);

    // Reset mid-REQ, late rvalid ignored
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("midrst_req_before", 32'(imem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_instr", instr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late_rvalid_no_done", 32'(fetch_done), 32'd0);
    @(negedge clk);
    chk("late_rvalid_no_done2", 32'(fetch_done), 32'd0);
    chk("late_rvalid_instr", instr, 32'h0);

    // Wrap-around
    pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0;
    chk("wrap_load_pc", pc, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 6'h00, 0, 32'h0, 32'h0, 1'b0, 32'h0, -1, 32'h0, 1'b0);
    chk("wrap_pc", pc, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("completion_count", 32'(done_cnt), 32'(pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
